// File: rtl/bitslip_aligner.sv
// bitslip_aligner: ISERDES word-alignment sequencer for the digitizer ADC lanes.
// Visits each enabled channel, bitslipping it until its word matches the test pattern.
module bitslip_aligner #(
    parameter int nch       = 8,
    parameter int dw        = 16,
    parameter int settle    = 16,
    parameter int checks    = 4,
    parameter int max_slips = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [nch-1:0]    chan_mask,
    input  logic [dw-1:0]     pattern,
    input  logic [nch*dw-1:0] adc_data,
    output logic [nch-1:0]    bitslip,
    output logic              busy,
    output logic              done,
    output logic [nch-1:0]    aligned,
    output logic [nch-1:0]    fail,
    output logic [nch*4-1:0]  slip_count
);

    // state   | meaning
    // IDLE    | waiting for start
    // SEL     | pick next pending channel, load settle timer
    // SETTLE  | wait for data to settle after select or slip
    // CHECK   | compare selected word against pattern
    // SLIP    | one-cycle bitslip pulse on the selected channel
    // DONE    | one-cycle done pulse, then back to IDLE

    localparam int CW = (nch > 1) ? $clog2(nch) : 1;
    localparam int TW = $clog2(settle + 1);
    localparam int MW = $clog2(checks + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [nch-1:0]  pend;
    logic [CW-1:0]   ch;
    logic [TW-1:0]   timer;
    logic [MW-1:0]   match_cnt;

    logic            found;
    logic [CW-1:0]   pick_idx;
    logic [dw-1:0]   cur_word;
    logic [3:0]      cur_slips;
    logic            is_match;
    logic            last_match;
    logic            slips_exhausted;
    logic [nch-1:0]  slip_onehot;

    // Pending bits are cleared as channels are taken, so the lowest set bit
    // is always the next channel above the previous one.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        for (int i = nch - 1; i >= 0; i--) begin
            if (pend[i]) begin
                found    = 1'b1;
                pick_idx = CW'(i);
            end
        end
    end

    always_comb begin
        cur_word        = adc_data[int'(ch)*dw +: dw];
        cur_slips       = slip_count[int'(ch)*4 +: 4];
        is_match        = (cur_word == pattern);
        last_match      = is_match && (match_cnt == MW'(checks - 1));
        slips_exhausted = (cur_slips == 4'(max_slips));
        slip_onehot     = nch'(1) << ch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_SEL;
                end
            end
            ST_SEL: begin
                state_nx = found ? ST_SETTLE : ST_DONE;
            end
            ST_SETTLE: begin
                if (timer == '0) begin
                    state_nx = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (is_match) begin
                    state_nx = last_match ? ST_SEL : ST_CHECK;
                end else begin
                    state_nx = slips_exhausted ? ST_SEL : ST_SLIP;
                end
            end
            ST_SLIP: begin
                state_nx = ST_SETTLE;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        // Abort overrides everything once busy; in IDLE a coincident start wins.
        if (abort && (state != ST_IDLE)) begin
            state_nx = ST_IDLE;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            bitslip <= '0;
        end else begin
            busy    <= (state_nx != ST_IDLE);
            done    <= (state_nx == ST_DONE);
            bitslip <= (state_nx == ST_SLIP) ? slip_onehot : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            ch        <= '0;
            timer     <= '0;
            match_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pend <= chan_mask;
                    end
                end
                ST_SEL: begin
                    if (found) begin
                        ch             <= pick_idx;
                        pend[pick_idx] <= 1'b0;
                        timer          <= TW'(settle - 1);
                    end
                end
                ST_SETTLE: begin
                    match_cnt <= '0;
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_CHECK: begin
                    if (is_match) begin
                        match_cnt <= match_cnt + MW'(1);
                    end
                end
                ST_SLIP: begin
                    timer <= TW'(settle - 1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result flags and slip counters; partial values survive an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aligned    <= '0;
            fail       <= '0;
            slip_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        aligned    <= '0;
                        fail       <= '0;
                        slip_count <= '0;
                    end
                end
                ST_CHECK: begin
                    if (state_nx == ST_SEL) begin
                        if (is_match) begin
                            aligned[ch] <= 1'b1;
                        end else begin
                            fail[ch] <= 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    slip_count[int'(ch)*4 +: 4] <= cur_slips + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitslip_aligner.sv
// Bench for bitslip_aligner: ISERDES rotation model drives adc_data, and an
// event-schedule model predicts every output on every cycle.
module tb_bitslip_aligner;

    localparam int NCH    = 8;
    localparam int DW     = 16;
    localparam int SETTLE = 4;
    localparam int CHECKS = 4;
    localparam int MAXS   = 8;
    localparam int BIG    = 1 << 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [NCH-1:0]    chan_mask;
    logic [DW-1:0]     pattern;
    logic [NCH*DW-1:0] adc_data;
    logic [NCH-1:0]    bitslip;
    logic              busy;
    logic              done;
    logic [NCH-1:0]    aligned;
    logic [NCH-1:0]    fail;
    logic [NCH*4-1:0]  slip_count;

    bitslip_aligner #(
        .nch(NCH), .dw(DW), .settle(SETTLE), .checks(CHECKS), .max_slips(MAXS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .chan_mask(chan_mask), .pattern(pattern), .adc_data(adc_data),
        .bitslip(bitslip), .busy(busy), .done(done), .aligned(aligned),
        .fail(fail), .slip_count(slip_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // ISERDES model: each bitslip rotates the channel's deserialized word by one bit.
    logic [15:0] base [NCH];
    int          off  [NCH] = '{default: 0};

    function automatic logic [15:0] rotl(input logic [15:0] w, input int n);
        int k;
        k = n % 16;
        if (k == 0) return w;
        return (w << k) | (w >> (16 - k));
    endfunction

    function automatic logic [15:0] rotr(input logic [15:0] w, input int n);
        return rotl(w, 16 - (n % 16));
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (bitslip[c] == 1'b1) off[c] <= off[c] + 1;
        end
    end

    always_comb begin
        adc_data = '0;
        for (int c = 0; c < NCH; c++) adc_data[c*DW +: DW] = rotl(base[c], off[c]);
    end

    // Schedule of the current run, in cycle numbers (value of cyc after the edge).
    int             s_t = BIG;
    int             done_t = BIG;
    int             stop_t = BIG;
    int             sel_t   [NCH];
    int             pulse_n [NCH];
    int             pulse_t [NCH][MAXS];
    int             res_t   [NCH];
    bit             res_ok  [NCH];
    bit             in_run  [NCH];
    int             exp_off [NCH] = '{default: 0};
    logic [NCH-1:0] init_al = '0;
    logic [NCH-1:0] init_fl = '0;
    logic [NCH*4-1:0] init_sc = '0;

    // {bitslip, busy, done, aligned, fail, slip_count}
    function automatic logic [57:0] expect_at(input int t);
        logic [NCH-1:0]   bs, al, fl;
        logic [NCH*4-1:0] sc;
        logic             bz, dn;
        int               tt, cnt;
        if (t < s_t) return {{NCH{1'b0}}, 1'b0, 1'b0, init_al, init_fl, init_sc};
        tt = (t < stop_t) ? t : stop_t - 1;
        bz = (t < stop_t);
        dn = (t == done_t) && bz;
        bs = '0; al = '0; fl = '0; sc = '0;
        for (int c = 0; c < NCH; c++) begin
            if (in_run[c]) begin
                cnt = 0;
                for (int j = 0; j < pulse_n[c]; j++) begin
                    if (pulse_t[c][j] < tt) cnt++;
                    if (bz && pulse_t[c][j] == t) bs[c] = 1'b1;
                end
                sc[c*4 +: 4] = 4'(cnt);
                if (tt >= res_t[c]) begin
                    if (res_ok[c]) al[c] = 1'b1;
                    else           fl[c] = 1'b1;
                end
            end
        end
        return {bs, bz, dn, al, fl, sc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare plus a few observations used by the literal checks.
    int done_cnt = 0;
    int done_seen = -1;
    int pulse_cnt  [NCH] = '{default: 0};
    int last_pulse [NCH] = '{default: -1000};

    initial begin
        forever begin
            @(negedge clk);
            check("outputs", 64'({bitslip, busy, done, aligned, fail, slip_count}), 64'(expect_at(cyc)));
            if (done) begin
                done_cnt++;
                done_seen = cyc;
            end
            for (int c = 0; c < NCH; c++) begin
                if (bitslip[c]) begin
                    check("slip_gap", 64'((cyc - last_pulse[c]) >= SETTLE + 2), 64'd1);
                    pulse_cnt[c]++;
                    last_pulse[c] = cyc;
                end
            end
        end
    end

    task automatic set_base(input int c, input int n);
        if (n < 0) base[c] = rotr(pattern, exp_off[c]) ^ 16'h0001;
        else       base[c] = rotr(pattern, exp_off[c] + n);
    endtask

    task automatic build(input logic [NCH-1:0] m);
        logic [57:0] cur;
        int t, n;
        cur = expect_at(cyc);
        init_al = cur[47:40];
        init_fl = cur[39:32];
        init_sc = cur[31:0];
        s_t = cyc + 1;
        t = s_t;
        for (int c = 0; c < NCH; c++) begin
            in_run[c] = m[c]; pulse_n[c] = 0; res_t[c] = BIG; sel_t[c] = BIG; res_ok[c] = 1'b0;
            if (m[c]) begin
                n = MAXS + 1;
                for (int k = MAXS; k >= 0; k--) begin
                    if (rotl(base[c], exp_off[c] + k) == pattern) n = k;
                end
                sel_t[c] = t;
                pulse_n[c] = (n <= MAXS) ? n : MAXS;
                for (int j = 0; j < pulse_n[c]; j++) pulse_t[c][j] = t + (j + 1) * (SETTLE + 2);
                if (n <= MAXS) begin
                    res_ok[c] = 1'b1;
                    t = t + n * (SETTLE + 2) + SETTLE + 1 + CHECKS;
                end else begin
                    t = t + MAXS * (SETTLE + 2) + SETTLE + 2;
                end
                res_t[c] = t;
            end
        end
        done_t = t + 1;
        stop_t = done_t + 1;
    endtask

    task automatic finish_run(input int cut);
        for (int c = 0; c < NCH; c++) begin
            if (in_run[c]) begin
                for (int j = 0; j < pulse_n[c]; j++) begin
                    if (pulse_t[c][j] < cut) exp_off[c]++;
                end
            end
        end
    endtask

    task automatic run(input logic [NCH-1:0] m);
        build(m);
        chan_mask = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_until(input int tgt);
        int g;
        g = 0;
        while (cyc < tgt && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        check("wait_bound", 64'(cyc), 64'(tgt));
    endtask

    task automatic wait_done();
        wait_until(stop_t);
        @(posedge clk); #1;
        finish_run(stop_t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_t = BIG;
        init_al = '0; init_fl = '0; init_sc = '0;
        for (int c = 0; c < NCH; c++) in_run[c] = 1'b0;
    endtask

    int p0, d0, a_t, p_t;
    logic [NCH-1:0] m_r;

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; chan_mask = '0; pattern = 16'hA5A5;
        for (int c = 0; c < NCH; c++) base[c] = 16'h0000;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_state", 64'({bitslip, busy, done, aligned, fail, slip_count}), 64'd0);

        // Test 1: channel 0 already aligned.
        pattern = 16'hA5A5;
        set_base(0, 0);
        p0 = pulse_cnt[0];
        run(8'h01);
        wait_done();
        check("t1_done_latency", 64'(done_seen - s_t), 64'd10);
        check("t1_aligned", 64'(aligned), 64'h01);
        check("t1_no_slip", 64'(pulse_cnt[0] - p0), 64'd0);

        // Test 2: channel 0 needs three slips.
        set_base(0, 3);
        p0 = pulse_cnt[0];
        run(8'h01);
        wait_done();
        check("t2_pulses", 64'(pulse_cnt[0] - p0), 64'd3);
        check("t2_slip_count", 64'(slip_count[3:0]), 64'd3);
        check("t2_aligned0", 64'(aligned[0]), 64'd1);

        // Test 3: channel 2 never matches.
        set_base(2, -1);
        p0 = pulse_cnt[2];
        d0 = done_cnt;
        run(8'h04);
        wait_done();
        check("t3_pulses", 64'(pulse_cnt[2] - p0), 64'd8);
        check("t3_fail", 64'(fail), 64'h04);
        check("t3_slip_count", 64'(slip_count[11:8]), 64'd8);
        check("t3_done", 64'(done_cnt - d0), 64'd1);

        // Test 4 and random runs: mixed good and bad channels.
        for (int r = 0; r < 7; r++) begin
            pattern = 16'($urandom);
            m_r = (r == 0) ? 8'hFF : 8'($urandom);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) set_base(c, -1);
                else set_base(c, int'($urandom_range(0, MAXS)));
            end
            run(m_r);
            wait_done();
            if (r == 0) begin
                check("t4_all_resolved", 64'(aligned | fail), 64'hFF);
                check("t4_exclusive", 64'(aligned & fail), 64'h00);
            end
        end

        // Test 5: abort during the second SETTLE of channel 1, then rerun.
        pattern = 16'hA5A5;
        set_base(0, 0);
        set_base(1, 2);
        d0 = done_cnt;
        run(8'h03);
        a_t = sel_t[1] + (SETTLE + 2) + 2;
        wait_until(a_t);
        abort = 1'b1;
        stop_t = a_t + 1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t5_busy_drop", 64'(busy), 64'd0);
        check("t5_aligned0_kept", 64'(aligned[0]), 64'd1);
        repeat (SETTLE + 4) @(posedge clk);
        #1;
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        finish_run(stop_t);
        set_base(1, 1);
        run(8'h03);
        check("t5_flags_cleared", 64'({aligned, fail, slip_count}), 64'd0);
        wait_done();
        check("t5_rerun_aligned", 64'(aligned), 64'h03);

        // Test 6: reset asserted while a bitslip pulse is driven.
        set_base(0, 2);
        run(8'h01);
        p_t = sel_t[0] + SETTLE + 2;
        wait_until(p_t);
        check("t6_pulse_live", 64'(bitslip), 64'h01);
        finish_run(p_t);
        do_reset();
        #1;
        check("t6_reset_clears", 64'({bitslip, busy, done, aligned, fail, slip_count}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run(8'h00);
        wait_done();
        check("t6_empty_done", 64'(done_seen - s_t), 64'd1);
        check("t6_empty_flags", 64'({aligned, fail}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bitslip_aligner.md
# bitslip_aligner

Automatic ISERDES word-alignment sequencer for the digitizer ADC lanes. The host puts the ADCs into test-pattern mode and pulses `start`. For each enabled channel in turn, the block waits for the data to settle, then compares the channel's 16-bit word against the expected pattern. On a mismatch it issues one bitslip pulse and retries. It sits in the `adc_clk` domain between the host register file and the per-chip bitslip inputs, replacing manual software bitslip sequencing.

## Interface
- `nch`, 8, number of ADC channels (one bitslip bit each)
- `dw`, 16, bits per channel word in `adc_data`
- `settle`, 16, wait cycles after channel select or after any bitslip pulse before comparing (≥1)
- `checks`, 4, consecutive matching cycles required to declare a channel aligned (≥1)
- `max_slips`, 8, bitslip pulses allowed per channel before declaring failure (≤15)

Ports:
- `clk`  in  1  `adc_clk`; all logic is on this single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a sequence.
- `abort`  in  1  single-cycle pulse that stops the sequence.
- `chan_mask`  in  nch  channels to align; sampled on the accepted `start`.
- `pattern`  in  dw  expected test-pattern word; held stable by the host during a run.
- `adc_data`  in  nch*dw  channel c occupies `adc_data[c*dw +: dw]`.
- `bitslip`  out  nch  one-hot, one-cycle pulses to the ISERDES.
- `busy`  out  1  high while a sequence runs.
- `done`  out  1  one-cycle pulse at normal completion.
- `aligned`  out  nch  per-channel success flags.
- `fail`  out  nch  per-channel failure flags.
- `slip_count`  out  nch*4  pulses issued per channel; channel c occupies `[c*4 +: 4]`.

## Operation
- States: IDLE, SEL, SETTLE, CHECK, SLIP, DONE.
- **IDLE**
  - `start` → SEL.
  - On the same edge: latch `chan_mask`, clear `aligned`, `fail` and `slip_count`, set `busy`.
- **SEL**
  - Picks the lowest-index channel that is still pending in the latched mask, above the previous channel.
  - A channel is found: load a timer with `settle`, go to SETTLE.
  - No channel remains: go to DONE.
- **SETTLE**
  - The timer counts down to 0, then the state goes to CHECK with the match counter cleared.
- **CHECK**, comparing the selected word against `pattern` each cycle:
  - Equal: increment the match counter. When it reaches `checks`, set `aligned[ch]` and go to SEL.
  - Not equal, with `slip_count[ch]` == `max_slips`: set `fail[ch]` and go to SEL.
  - Not equal otherwise: go to SLIP.
- **SLIP**
  - `bitslip[ch]`=1 for exactly this one cycle.
  - Increment `slip_count[ch]`, reload the timer with `settle`, go to SETTLE.
- **DONE**
  - `done`=1 for one cycle, `busy`=0 from the next cycle, then IDLE.
- `start` while busy is ignored.
- `abort` in any non-IDLE state:
  - The next state is IDLE, `busy` drops on the next edge and no `done` is issued.
  - `aligned`, `fail` and `slip_count` keep their partial values.
  - A `bitslip` pulse already being driven is not extended.
- If `abort` and `start` arrive together in IDLE, `start` wins. If they arrive together while busy, `abort` wins.
- Channels whose mask bit is 0 keep `aligned`=`fail`=0 and `slip_count`=0.

## Timing
- **Reset:** async assert forces IDLE and drives every output to 0, at any point including mid-sequence. A `bitslip` pulse is cut immediately.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.
- **Start to busy:** `start` is sampled at edge k, `busy`=1 after edge k, and SEL occupies cycle k+1.
- **Channel aligned with 0 slips:** 1 (SEL) + `settle` + `checks` cycles.
- **Each slip adds:** (mismatch cycle) + 1 (SLIP) + `settle` cycles.
- **Failed channel:** `max_slips` pulses in total, and the flag is set on the (`max_slips`+1)th mismatch.
- **Pulse spacing:** consecutive `bitslip` pulses to the same channel are never closer than `settle`+2 cycles.
- **Empty mask:** `done` is high in cycle k+2, with `aligned`=`fail`=0.
- **Flag timing:** `aligned`/`fail` bits are set on the same edge the FSM leaves CHECK, so they are valid no later than `done`.

## Test plan
1. With `settle`=4, `checks`=4, mask=8'h01, and channel 0 always equal to `pattern` 16'hA5A5: no bitslip; `aligned`=8'h01; `done` exactly 1+4+4+1 cycles after the start cycle.
2. Channel 0 matches only after 3 bitslip pulses (model rotates the word per slip): 3 one-cycle `bitslip[0]` pulses each ≥6 cycles apart; `slip_count[3:0]`=3; `aligned[0]`=1.
3. Channel 2 never matches, mask=8'h04: exactly 8 pulses on `bitslip[2]`; `fail`=8'h04; `slip_count[11:8]`=8; `done` pulses.
4. Mask=8'hFF with mixed good and bad channels: channels are visited in ascending order; `aligned | fail` = 8'hFF; `aligned & fail` = 0.
5. `abort` during the second SETTLE of channel 1: `busy`=0 next cycle; no `done`; `aligned[0]` is retained. A later `start` clears the flags and reruns.
6. `rst_n` asserted mid-SLIP: `bitslip`, `busy` and all flags are 0 immediately; after release, `start` with mask=0 gives `done` at k+2.
